// File: rtl/render_pkg.sv
// Shared rendering constants and helpers used by the sprite pipeline and compositor.
package render_pkg;

    localparam int RGB_W    = 12;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int COORD_W  = 10;

    // Bit offset of layer i inside a packed per-layer colour bus.
    function automatic int layer_slice(input int i);
        return i * RGB_W;
    endfunction

endpackage

// File: rtl/prio_select.sv
// Combinational highest-index-wins selector over a packed vector of N entries of W bits.
module prio_select #(
    parameter int N = 4,
    parameter int W = 12
) (
    input  logic [N-1:0]   valid,
    input  logic [N*W-1:0] data,
    output logic [W-1:0]   sel,
    output logic           found
);

    // Ascending scan so that a later (higher-index) valid entry overrides earlier ones.
    always_comb begin
        sel   = {W{1'b0}};
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (valid[i]) begin
                sel   = data[i*W +: W];
                found = 1'b1;
            end else begin
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage layer compositor: priority merge of sprite layers over a background,
// with blink/enable masking and per-frame collision reporting for the top layer.
module layer_compositor
    import render_pkg::*;
#(
    parameter int                   LAYER_NUM  = 18,
    parameter int                   RGB_W      = render_pkg::RGB_W,
    parameter logic [LAYER_NUM-1:0] HIT_MASK   = {LAYER_NUM{1'b1}} >> 1,
    parameter logic [LAYER_NUM-1:0] BLINK_MASK = {LAYER_NUM{1'b0}},
    localparam int                  IDX_W      = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [COORD_W-1:0]         col,
    input  logic [COORD_W-1:0]         row,
    input  logic [RGB_W-1:0]           bg_rgb,
    input  logic [LAYER_NUM-1:0]       layer_hit,
    input  logic [LAYER_NUM*RGB_W-1:0] layer_rgb,
    input  logic [LAYER_NUM-1:0]       layer_en,
    input  logic                       blink,
    output logic [RGB_W-1:0]           rgb_out,
    output logic                       frame_hit,
    output logic [IDX_W-1:0]           hit_idx,
    output logic                       frame_done
);

    logic [LAYER_NUM-1:0]       v_s;
    logic                       coll_s;
    logic [IDX_W-1:0]           coll_idx_s;
    logic                       sof_s;

    logic [LAYER_NUM-1:0]       v_r;
    logic [LAYER_NUM*RGB_W-1:0] rgb_r;
    logic [RGB_W-1:0]           bg_r;
    logic                       coll_r;
    logic [IDX_W-1:0]           coll_idx_r;
    logic                       sof_r;

    logic [RGB_W-1:0]           sel_rgb_s;
    logic                       sel_found_s;
    logic [RGB_W-1:0]           pix_s;

    logic                       acc_hit_r;
    logic [IDX_W-1:0]           acc_idx_r;

    assign v_s   = layer_hit & layer_en & ~(BLINK_MASK & {LAYER_NUM{blink}});
    assign sof_s = (col == {COORD_W{1'b0}}) && (row == {COORD_W{1'b0}});

    // The top layer collides with the highest-index valid hazard layer below it.
    if (LAYER_NUM > 1) begin : g_coll
        localparam int HN = LAYER_NUM - 1;

        logic [HN-1:0]       hazard_s;
        logic [HN*IDX_W-1:0] idx_tab_s;
        logic [IDX_W-1:0]    haz_idx_s;
        logic                haz_found_s;

        assign hazard_s = v_s[HN-1:0] & HIT_MASK[HN-1:0];

        for (genvar g = 0; g < HN; g++) begin : g_tab
            assign idx_tab_s[g*IDX_W +: IDX_W] = IDX_W'(g);
        end

        prio_select #(
            .N (HN),
            .W (IDX_W)
        ) u_hazard_sel (
            .valid (hazard_s),
            .data  (idx_tab_s),
            .sel   (haz_idx_s),
            .found (haz_found_s)
        );

        assign coll_s     = v_s[HN] & haz_found_s;
        assign coll_idx_s = haz_idx_s;
    end else begin : g_no_coll
        assign coll_s     = 1'b0;
        assign coll_idx_s = {IDX_W{1'b0}};
    end

    // Stage 1: register masked valids, colours, collision result and frame-start flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r        <= {LAYER_NUM{1'b0}};
            rgb_r      <= {(LAYER_NUM*RGB_W){1'b0}};
            bg_r       <= {RGB_W{1'b0}};
            coll_r     <= 1'b0;
            coll_idx_r <= {IDX_W{1'b0}};
            sof_r      <= 1'b0;
        end else begin
            v_r        <= v_s;
            rgb_r      <= layer_rgb;
            bg_r       <= bg_rgb;
            coll_r     <= coll_s;
            coll_idx_r <= coll_idx_s;
            sof_r      <= sof_s;
        end
    end

    prio_select #(
        .N (LAYER_NUM),
        .W (RGB_W)
    ) u_color_sel (
        .valid (v_r),
        .data  (rgb_r),
        .sel   (sel_rgb_s),
        .found (sel_found_s)
    );

    // Background shows through wherever no layer is valid.
    always_comb begin
        pix_s = bg_r;
        if (sel_found_s) begin
            pix_s = sel_rgb_s;
        end else begin
            pix_s = bg_r;
        end
    end

    // Stage 2: output pixel, frame report and collision accumulator.
    // At frame start the accumulator restarts with the (0,0) pixel's own result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out    <= {RGB_W{1'b0}};
            frame_hit  <= 1'b0;
            hit_idx    <= {IDX_W{1'b0}};
            frame_done <= 1'b0;
            acc_hit_r  <= 1'b0;
            acc_idx_r  <= {IDX_W{1'b0}};
        end else begin
            rgb_out <= pix_s;
            if (sof_r) begin
                frame_hit  <= acc_hit_r;
                hit_idx    <= acc_idx_r;
                frame_done <= 1'b1;
                acc_hit_r  <= coll_r;
                acc_idx_r  <= coll_r ? coll_idx_r : {IDX_W{1'b0}};
            end else begin
                frame_done <= 1'b0;
                if (coll_r && !acc_hit_r) begin
                    acc_hit_r <= 1'b1;
                    acc_idx_r <= coll_idx_r;
                end else begin
                    acc_hit_r <= acc_hit_r;
                    acc_idx_r <= acc_idx_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Directed and randomized bench for layer_compositor with a frame-level reference model.
module tb_layer_compositor;
    import render_pkg::*;

    localparam int         L  = 4;
    localparam logic [3:0] HM = 4'b0011;
    localparam logic [3:0] BM = 4'b0010;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  col, row;
    logic [11:0] bg_rgb;
    logic [3:0]  layer_hit, layer_en;
    logic [47:0] layer_rgb;
    logic        blink;
    logic [11:0] rgb_out;
    logic        frame_hit;
    logic [1:0]  hit_idx;
    logic        frame_done;

    always #5 clk = ~clk;

    layer_compositor #(
        .LAYER_NUM  (L),
        .RGB_W      (12),
        .HIT_MASK   (HM),
        .BLINK_MASK (BM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .col        (col),
        .row        (row),
        .bg_rgb     (bg_rgb),
        .layer_hit  (layer_hit),
        .layer_rgb  (layer_rgb),
        .layer_en   (layer_en),
        .blink      (blink),
        .rgb_out    (rgb_out),
        .frame_hit  (frame_hit),
        .hit_idx    (hit_idx),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [11:0] rgb;
        logic        coll;
        logic [1:0]  idx;
        logic        sof;
    } pix_t;

    int   checks = 0;
    int   errors = 0;
    pix_t pend = '0;
    logic m_acc = 1'b0;
    logic [1:0] m_acc_idx = 2'd0;
    logic m_fh = 1'b0;
    logic [1:0] m_fi = 2'd0;
    logic m_fd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // What the pixel on the inputs should look like once composited.
    function automatic pix_t model_pixel();
        pix_t p;
        logic [3:0] v;
        p.rgb  = bg_rgb;
        p.coll = 1'b0;
        p.idx  = 2'd0;
        p.sof  = (col == 10'd0) && (row == 10'd0);
        for (int i = 0; i < L; i++)
            v[i] = layer_hit[i] && layer_en[i] && !(blink && BM[i]);
        for (int i = L - 1; i >= 0; i--) begin
            if (v[i]) begin
                p.rgb = layer_rgb[layer_slice(i) +: 12];
                break;
            end
        end
        if (v[L-1]) begin
            for (int i = L - 2; i >= 0; i--) begin
                if (v[i] && HM[i]) begin
                    p.coll = 1'b1;
                    p.idx  = i[1:0];
                    break;
                end
            end
        end
        return p;
    endfunction

    task automatic step(input logic do_rst);
        pix_t        cur;
        logic [11:0] e_rgb;
        cur = model_pixel();
        rst = do_rst;
        @(posedge clk);
        #1;
        if (do_rst) begin
            m_fh = 1'b0; m_fi = 2'd0; m_fd = 1'b0;
            m_acc = 1'b0; m_acc_idx = 2'd0;
            e_rgb = 12'h000;
            pend = '0;
        end else begin
            e_rgb = pend.rgb;
            if (pend.sof) begin
                m_fh = m_acc;
                m_fi = m_acc_idx;
                m_fd = 1'b1;
                m_acc = pend.coll;
                m_acc_idx = pend.coll ? pend.idx : 2'd0;
            end else begin
                m_fd = 1'b0;
                if (pend.coll && !m_acc) begin
                    m_acc = 1'b1;
                    m_acc_idx = pend.idx;
                end
            end
            pend = cur;
        end
        chk("rgb_out", 32'(rgb_out), 32'(e_rgb));
        chk("frame_hit", 32'(frame_hit), 32'(m_fh));
        chk("hit_idx", 32'(hit_idx), 32'(m_fi));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        rst = 1'b0;
    endtask

    task automatic drive(input int c, input int r, input logic [3:0] hit, input logic [3:0] en,
                         input logic [11:0] bg, input logic bl);
        col = c[9:0];
        row = r[9:0];
        layer_hit = hit;
        layer_en = en;
        bg_rgb = bg;
        blink = bl;
    endtask

    task automatic set_rgb(input int i, input logic [11:0] c);
        layer_rgb[layer_slice(i) +: 12] = c;
    endtask

    initial begin
        rst = 1'b1;
        layer_rgb = 48'd0;
        drive(0, 0, 4'h0, 4'h0, 12'h000, 1'b0);
        step(1'b1);
        step(1'b1);
        chk("reset_rgb", 32'(rgb_out), 32'h000);
        chk("reset_done", 32'(frame_done), 32'h0);

        set_rgb(0, 12'hA00); set_rgb(1, 12'h0B0); set_rgb(2, 12'h00C); set_rgb(3, 12'hFFF);
        drive(10, 10, 4'b0111, 4'b1111, 12'h111, 1'b0); step(1'b0);
        drive(11, 10, 4'b0111, 4'b1011, 12'h111, 1'b0); step(1'b0);
        chk("prio_top", 32'(rgb_out), 32'h00C);
        drive(12, 10, 4'b0000, 4'b1111, 12'h5A5, 1'b0); step(1'b0);
        chk("prio_en_off", 32'(rgb_out), 32'h0B0);
        set_rgb(1, 12'h0F0);
        drive(13, 10, 4'b0010, 4'b1111, 12'h123, 1'b1); step(1'b0);
        chk("background", 32'(rgb_out), 32'h5A5);
        drive(14, 10, 4'b0010, 4'b1111, 12'h123, 1'b0); step(1'b0);
        chk("blink_on", 32'(rgb_out), 32'h123);
        drive(0, 0, 4'b0000, 4'b1111, 12'h000, 1'b0); step(1'b0);
        chk("blink_off", 32'(rgb_out), 32'h0F0);

        drive(100, 200, 4'b1010, 4'b1111, 12'h000, 1'b0); step(1'b0);
        chk("clean_done", 32'(frame_done), 32'h1);
        chk("clean_hit", 32'(frame_hit), 32'h0);
        drive(300, 200, 4'b1001, 4'b1111, 12'h000, 1'b0); step(1'b0);
        drive(301, 200, 4'b0000, 4'b1111, 12'h000, 1'b0); step(1'b0);
        drive(0, 0, 4'b0000, 4'b1111, 12'h000, 1'b0); step(1'b0);
        chk("coll_pre_done", 32'(frame_done), 32'h0);
        drive(1, 0, 4'b0000, 4'b1111, 12'h000, 1'b0); step(1'b0);
        chk("coll_done", 32'(frame_done), 32'h1);
        chk("coll_hit", 32'(frame_hit), 32'h1);
        chk("coll_idx", 32'(hit_idx), 32'h1);
        drive(2, 0, 4'b0000, 4'b1111, 12'h000, 1'b0); step(1'b0);
        chk("coll_pulse_end", 32'(frame_done), 32'h0);

        drive(5, 5, 4'b1100, 4'b1111, 12'h000, 1'b0); step(1'b0);
        drive(0, 0, 4'b0000, 4'b1111, 12'h000, 1'b0); step(1'b0);
        chk("nonhaz_rgb", 32'(rgb_out), 32'hFFF);
        drive(1, 0, 4'b0000, 4'b1111, 12'h000, 1'b0); step(1'b0);
        chk("nonhaz_done", 32'(frame_done), 32'h1);
        chk("nonhaz_hit", 32'(frame_hit), 32'h0);

        drive(50, 50, 4'b1001, 4'b1111, 12'h456, 1'b0); step(1'b0);
        drive(60, 50, 4'b0000, 4'b1111, 12'h456, 1'b0); step(1'b1);
        chk("rst_mid_rgb", 32'(rgb_out), 32'h000);
        chk("rst_mid_hit", 32'(frame_hit), 32'h0);
        chk("rst_mid_done", 32'(frame_done), 32'h0);
        drive(61, 50, 4'b0000, 4'b1111, 12'h456, 1'b0); step(1'b0);
        drive(0, 0, 4'b0000, 4'b1111, 12'h456, 1'b0); step(1'b0);
        drive(1, 0, 4'b0000, 4'b1111, 12'h456, 1'b0); step(1'b0);
        chk("rst_frame_done", 32'(frame_done), 32'h1);
        chk("rst_frame_hit", 32'(frame_hit), 32'h0);

        for (int n = 0; n < 400; n++) begin
            logic [3:0] en;
            en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            for (int i = 0; i < L; i++) set_rgb(i, 12'($urandom));
            if ($urandom_range(0, 7) == 0)
                drive(0, 0, 4'($urandom), en, 12'($urandom), 1'($urandom));
            else
                drive(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                      4'($urandom), en, 12'($urandom), 1'($urandom));
            step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised, pipelined pixel compositor that merges a background colour with `LAYER_NUM` sprite layers into one VGA pixel per clock. It sits between the sprite generators (scene, clouds, apples, kid) and the VGA output register. It adds four features: per-layer enable, blink masking, a fixed two-cycle latency, and per-frame collision detection between the top layer (the kid) and a configurable set of hazard layers.

## Interface
- `LAYER_NUM`, 18: number of sprite layers. Index 0 has the lowest priority; index `LAYER_NUM-1` is the top layer (the kid).
- `RGB_W`, 12: colour width per layer.
- `HIT_MASK`, all ones except the top bit: set bit i means layer i is a hazard for collision with the top layer.
- `BLINK_MASK`, 0: set bit i means layer i is suppressed while `blink` is high.
- `clk`, in, 1: pixel clock. One clock domain only; reset is synchronous and active-high.
- `rst`, in, 1: synchronous, active-high reset.
- `col`, in, 10: current pixel column.
- `row`, in, 10: current pixel row.
- `bg_rgb`, in, `RGB_W`: background (scene) colour.
- `layer_hit`, in, `LAYER_NUM`: bit i means layer i covers this pixel.
- `layer_rgb`, in, `LAYER_NUM*RGB_W`: colour of layer i at bits `[i*RGB_W +: RGB_W]`.
- `layer_en`, in, `LAYER_NUM`: runtime enable per layer. A disabled layer is never drawn and never collides.
- `blink`, in, 1: blink phase; intended to be driven from a slow `clkdiv` bit.
- `rgb_out`, out, `RGB_W`: composited pixel.
- `frame_hit`, out, 1: a collision occurred during the last completed frame.
- `hit_idx`, out, `$clog2(LAYER_NUM)`: index of the hazard layer from the first colliding pixel of the last frame.
- `frame_done`, out, 1: one-cycle pulse when `frame_hit` and `hit_idx` update.

## Operation
- Effective valid for layer i: `v[i] = layer_hit[i] & layer_en[i] & ~(blink & BLINK_MASK[i])`.
- Priority: the highest-index valid layer wins. If no layer is valid, `bg_rgb` is output.
- Collision at a pixel means `v[LAYER_NUM-1]` is set and `v[i] & HIT_MASK[i]` is set for some i < `LAYER_NUM-1`. The colliding index is the highest such i.
- Collision accumulator:
  - `acc_hit` is sticky and is set on the first colliding pixel of a frame.
  - `acc_idx` is captured only when `acc_hit` goes from 0 to 1. Later collisions in the same frame do not change it.
- Frame boundary is the stage-1 input pixel with `col==0 && row==0`. On that cycle:
  - `frame_hit <= acc_hit` and `hit_idx <= acc_idx`.
  - `frame_done` pulses for one cycle.
  - The accumulator restarts with that pixel's own collision result, so a collision at (0,0) belongs to the new frame.
- `blink` and `layer_en` are sampled per pixel. A change in the middle of a frame takes effect on the next pixel; no mid-frame masking is held over.

## Timing
- Stage 1 (registered): `v`, the layer colours, `bg_rgb`, the collision flag with its index, and the frame-start flag.
- Stage 2 (registered): the priority-selected colour goes to `rgb_out`.
- Latency from input to `rgb_out` is exactly 2 cycles; throughput is 1 pixel per clock. The VGA sync generator must delay hsync/vsync by 2 cycles to match.
- The accumulator and the frame outputs update on the stage-1 to stage-2 edge. `frame_done` is asserted 2 cycles after (0,0) is presented at the inputs.
- Reset values: `rgb_out` 0, `frame_hit` 0, `hit_idx` 0, `frame_done` 0, all pipeline registers 0, accumulator cleared.
- Reset in the middle of a frame discards partial accumulation. The first `frame_done` after reset reports only the pixels seen since reset.
- If `LAYER_NUM==1`, collision is never possible; `frame_hit` stays 0.

## Structure
- Shared package `render_pkg`:
  - constants `RGB_W=12`, `H_ACTIVE=640`, `V_ACTIVE=480`, `COORD_W=10`;
  - the function `layer_slice(i)` returning the colour bit offset for layer i.
- Sub-module `prio_select`: a purely combinational highest-index-wins selector. It takes a valid vector plus a packed vector, returns the selected value and a `found` flag, and is parametrised on N and W. It is used once for colour selection in stage 2 and once for the hazard index in stage 1.

## Test plan
All scenarios use `LAYER_NUM=4` and `HIT_MASK=4'b0011`.
- Priority: `bg=0x111`, layers 0, 1 and 2 all hit with colours 0xA00, 0x0B0, 0x00C, enables all 1 -> `rgb_out=0x00C` exactly 2 cycles later. With `layer_en[2]=0` -> `rgb_out=0x0B0`.
- Background: `layer_hit=0`, `bg=0x5A5` -> `rgb_out=0x5A5` after 2 cycles; `frame_hit` stays 0 at the next frame end.
- Blink: `BLINK_MASK=4'b0010`, only layer 1 hit with colour 0x0F0. With `blink=1` -> `rgb_out=bg`; with `blink=0` -> `rgb_out=0x0F0`.
- Collision: during one frame, layers 3 and 1 overlap at (100,200), then layers 3 and 0 overlap at (300,200). At the next (0,0): `frame_done` pulses once, `frame_hit=1`, `hit_idx=1`. A following clean frame gives `frame_hit=0`.
- Non-hazard overlap: layers 3 and 2 overlap, and layer 2 is not in `HIT_MASK` -> `frame_hit=0`, and `rgb_out` shows layer 3's colour.
- Reset mid-frame: collide at (50,50), assert `rst` for 1 cycle at (60,50) -> all outputs 0 the following cycle; the next `frame_done` reports `frame_hit=0`.
